// File: rtl/ed_line_window_if.sv
// Pixel-in / window-out bundle for ed_line_window.
// master = pixel source plus window consumer, slave = the line-window block.
interface ed_line_window_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [11:0] pix_in;
    logic        pix_ready;
    logic [11:0] top_line_out;
    logic [11:0] mid_line_out;
    logic [11:0] bot_line_out;
    logic        win_valid;
    logic        ctr_valid;
    logic        at_left;
    logic        at_right;
    logic        at_top;
    logic        at_bottom;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  pix_ready, top_line_out, mid_line_out, bot_line_out,
        input  win_valid, ctr_valid, at_left, at_right, at_top, at_bottom
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output pix_ready, top_line_out, mid_line_out, bot_line_out,
        output win_valid, ctr_valid, at_left, at_right, at_top, at_bottom
    );
endinterface

// File: rtl/ed_line_window.sv
// Raster-to-3x3-window feeder: two line memories, one flush column per row, one flush row per frame.
// Optional ED_LINE_WINDOW_SOF_ABORT_EN: pix_sof outside IDLE restarts the frame.
module ed_line_window #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    ed_line_window_if.slave   bus,
    output logic [2:0]        state_dbg
);
    localparam int XW = $clog2(IMG_WIDTH + 1);
    localparam int YW = $clog2(IMG_HEIGHT + 1);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [XW-1:0] X_END  = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_END  = YW'(IMG_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRIME     = 3'd1,
        S_RUN       = 3'd2,
        S_COL_FLUSH = 3'd3,
        S_ROW_FLUSH = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [11:0]     l1_mem [IMG_WIDTH];
    logic [11:0]     l2_mem [IMG_WIDTH];
    logic [AW-1:0]   rd_addr, wr_addr;
    logic            accept, sof_abort, mem_we, emit;
    logic [11:0]     top_d, mid_d, bot_d;
    logic [11:0]     top_q, mid_q, bot_q;
    logic            win_valid_q, ctr_valid_q;
    logic            at_left_q, at_right_q, at_top_q, at_bottom_q;

    // Handshake: a pixel transfers on any cycle where pix_valid and pix_ready are both high;
    // pix_ready depends on state only, and win_valid pulses once per presented triplet.
    assign bus.pix_ready = (state_q == S_IDLE) || (state_q == S_PRIME) || (state_q == S_RUN);
    assign accept        = bus.pix_valid & bus.pix_ready;
    assign rd_addr       = x_q[AW-1:0];
    assign state_dbg     = state_q;

`ifdef ED_LINE_WINDOW_SOF_ABORT_EN
    assign sof_abort = accept & bus.pix_sof & (state_q != S_IDLE);
`else
    assign sof_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mem_we  = 1'b0;
        wr_addr = rd_addr;
        emit    = 1'b0;
        top_d   = 12'h000;
        mid_d   = 12'h000;
        bot_d   = 12'h000;
        if (sof_abort || (state_q == S_IDLE && accept && bus.pix_sof)) begin
            // Start-of-frame pixel lands at (0,0) regardless of where the counters were.
            mem_we  = 1'b1;
            wr_addr = '0;
            x_d     = XW'(1);
            y_d     = '0;
            state_d = S_PRIME;
        end else begin
            case (state_q)
                S_PRIME: if (accept) begin
                    mem_we = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        y_d     = YW'(1);
                        state_d = S_RUN;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
                S_RUN: if (accept) begin
                    mem_we = 1'b1;
                    emit   = 1'b1;
                    top_d  = l2_mem[rd_addr];
                    mid_d  = l1_mem[rd_addr];
                    bot_d  = bus.pix_in;
                    if (x_q == X_LAST) begin
                        x_d     = X_END;
                        state_d = S_COL_FLUSH;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
                S_COL_FLUSH: begin
                    emit = 1'b1;
                    x_d  = '0;
                    y_d  = y_q + YW'(1);
                    state_d = (y_q + YW'(1) == Y_END) ? S_ROW_FLUSH : S_RUN;
                end
                S_ROW_FLUSH: begin
                    emit = 1'b1;
                    if (x_q == X_END) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        top_d = l2_mem[rd_addr];
                        mid_d = l1_mem[rd_addr];
                        x_d   = x_q + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            top_q       <= 12'h000;
            mid_q       <= 12'h000;
            bot_q       <= 12'h000;
            win_valid_q <= 1'b0;
            ctr_valid_q <= 1'b0;
            at_left_q   <= 1'b0;
            at_right_q  <= 1'b0;
            at_top_q    <= 1'b0;
            at_bottom_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            win_valid_q <= emit;
            if (emit) begin
                // Flags describe the centre (x-1, y-1) of the triplet being shifted in.
                top_q       <= top_d;
                mid_q       <= mid_d;
                bot_q       <= bot_d;
                ctr_valid_q <= (x_q != '0);
                at_left_q   <= (x_q == XW'(1));
                at_right_q  <= (x_q == X_END);
                at_top_q    <= (y_q == YW'(1));
                at_bottom_q <= (y_q == Y_END);
            end
        end
    end

    // Line memories are not reset; reads see pre-write data at the same address.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            l2_mem[wr_addr] <= l1_mem[wr_addr];
            l1_mem[wr_addr] <= bus.pix_in;
        end
    end

    assign bus.top_line_out = top_q;
    assign bus.mid_line_out = mid_q;
    assign bus.bot_line_out = bot_q;
    assign bus.win_valid    = win_valid_q;
    assign bus.ctr_valid    = ctr_valid_q;
    assign bus.at_left      = at_left_q;
    assign bus.at_right     = at_right_q;
    assign bus.at_top       = at_top_q;
    assign bus.at_bottom    = at_bottom_q;
endmodule
